// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line settings, data width and receiver FSM encodings.
// The transmitter uses the same defaults so both ends of the link agree.
package uart_rx_pkg;

    localparam int DEFAULT_CLK_FREQ = 27000000;
    localparam int DEFAULT_BAUD     = 115200;
    localparam int UART_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte with valid/frame_err pulses and busy out.
// master drives the line and observes results; slave is the receiver itself.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      frame_err;
    logic                      busy;

    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);

endinterface : uart_rx_if

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with a selectable reset value
// so an idle-high line does not look like activity while leaving reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling from a synchronized line.
// Emits one-cycle valid / frame_err pulses; data holds the last good byte.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                      rx_s;
    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      busy_q, busy_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; every count is bounded by its state so cnt never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Output decode: pulses come only from the stop-bit sample
    always_comb begin
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        if ((state_q == ST_STOP) && (cnt_q == BIT_LAST)) begin
            if (rx_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at default settings (234 clocks per bit).
module tb_uart_rx;

    localparam int CPB     = 27000000 / 115200;
    localparam int HALF    = CPB / 2;
    localparam int LAT_EXP = 2 + HALF + 9 * CPB;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;

    int         valid_cnt;
    int         ferr_cnt;
    int         both_cnt;
    int         long_cnt;
    int         busy_falls;
    int         last_valid_cyc;
    logic       prev_valid;
    logic       prev_ferr;
    logic       prev_busy;
    logic [7:0] data_log[$];

    uart_rx_if bus();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            valid_cnt      = valid_cnt + 1;
            last_valid_cyc = cyc;
            data_log.push_back(bus.data);
            if (prev_valid === 1'b1) long_cnt = long_cnt + 1;
        end
        if (bus.frame_err === 1'b1) begin
            ferr_cnt = ferr_cnt + 1;
            if (prev_ferr === 1'b1) long_cnt = long_cnt + 1;
        end
        if ((bus.valid === 1'b1) && (bus.frame_err === 1'b1)) both_cnt = both_cnt + 1;
        if ((prev_busy === 1'b1) && (bus.busy === 1'b0)) busy_falls = busy_falls + 1;
        prev_valid = bus.valid;
        prev_ferr  = bus.frame_err;
        prev_busy  = bus.busy;
    end

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_val);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
        drive_bit(stop_val, bclk);
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.data); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int v0, f0, t0, lat;
        v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
        send_byte(8'h55, CPB, 1'b1);
        repeat (CPB) @(negedge clk);
        lat = last_valid_cyc - t0;
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0); end
        total++; if (bus.data !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", bus.data); end
        total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
        total++; if ((lat < LAT_EXP - 2) || (lat > LAT_EXP + 2)) begin
            bad++; $display("FAIL single_latency got=%0d exp=%0d+-2", lat, LAT_EXP);
        end
    endtask

    task automatic test_back_to_back();
        int v0, f0, b0, n0;
        logic [7:0] exp_b[3];
        exp_b[0] = 8'hA3; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_falls; n0 = data_log.size();
        for (int k = 0; k < 3; k++) send_byte(exp_b[k], CPB, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (valid_cnt - v0 !== 3) begin bad++; $display("FAIL b2b_valid_count got=%0d exp=3", valid_cnt - v0); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (data_log.size() <= n0 + k) begin
                bad++; $display("FAIL b2b_data%0d got=none exp=%h", k, exp_b[k]);
            end else if (data_log[n0 + k] !== exp_b[k]) begin
                bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, data_log[n0 + k], exp_b[k]);
            end
        end
        total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
        total++; if (busy_falls - b0 !== 3) begin bad++; $display("FAIL b2b_busy_falls got=%0d exp=3", busy_falls - b0); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        logic busy_seen;
        v0 = valid_cnt; f0 = ferr_cnt; busy_seen = 1'b0;
        bus.rx = 1'b0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (bus.busy === 1'b1) busy_seen = 1'b1; end
        bus.rx = 1'b1;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (bus.busy === 1'b1) busy_seen = 1'b1; end
        total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=%b exp=1", busy_seen); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", bus.busy); end
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
        total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
        send_byte(8'h3C, CPB, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL glitch_next_valid got=%0d exp=1", valid_cnt - v0); end
        total++; if (bus.data !== 8'h3C) begin bad++; $display("FAIL glitch_next_data got=%h exp=3c", bus.data); end
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h41, CPB, 1'b0);
        drive_bit(1'b0, 3 * CPB);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
        total++; if (bus.data !== 8'h3C) begin bad++; $display("FAIL ferr_data_hold got=%h exp=3c", bus.data); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_low_line got=%b exp=1", bus.busy); end
        drive_bit(1'b1, 2 * CPB);
        send_byte(8'h42, CPB, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_after_count got=%0d exp=1", ferr_cnt - f0); end
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL ferr_next_valid got=%0d exp=1", valid_cnt - v0); end
        total++; if (bus.data !== 8'h42) begin bad++; $display("FAIL ferr_next_data got=%h exp=42", bus.data); end
    endtask

    task automatic test_mid_reset();
        int v0, f0;
        logic [7:0] b;
        v0 = valid_cnt; f0 = ferr_cnt; b = 8'h7E;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
        drive_bit(b[4], HALF);
        rst    = 1'b0;
        bus.rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", bus.data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
        repeat (2 * CPB) @(negedge clk);
        total++; if ((valid_cnt !== v0) || (ferr_cnt !== f0)) begin
            bad++; $display("FAIL midrst_no_pulse got=%0d/%0d exp=0/0", valid_cnt - v0, ferr_cnt - f0);
        end
        send_byte(8'h81, CPB, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL midrst_next_valid got=%0d exp=1", valid_cnt - v0); end
        total++; if (bus.data !== 8'h81) begin bad++; $display("FAIL midrst_next_data got=%h exp=81", bus.data); end
    endtask

    task automatic test_baud_skew();
        int v0, f0;
        int bclk[2];
        bclk[0] = 229; bclk[1] = 239;
        for (int k = 0; k < 2; k++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_byte(8'hC5, bclk[k], 1'b1);
            repeat (CPB) @(negedge clk);
            total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL skew%0d_valid got=%0d exp=1", bclk[k], valid_cnt - v0); end
            total++; if (bus.data !== 8'hC5) begin bad++; $display("FAIL skew%0d_data got=%h exp=c5", bclk[k], bus.data); end
            total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL skew%0d_ferr got=%0d exp=0", bclk[k], ferr_cnt - f0); end
        end
    endtask

    task automatic test_pulse_shape();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
        total++; if (long_cnt !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", long_cnt); end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        valid_cnt = 0; ferr_cnt = 0; both_cnt = 0; long_cnt = 0; busy_falls = 0;
        last_valid_cyc = 0; prev_valid = 1'b0; prev_ferr = 1'b0; prev_busy = 1'b0;
        rst = 1'b0; bus.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_mid_reset();
        test_baud_skew();
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
